// File: rtl/risc_pkg.sv
// Shared instruction-memory constants and the program-loader state encoding.
// ST_GET_CHK exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package risc_pkg;

   localparam int ADDR_W  = 8;
   localparam int INSTR_W = 16;
   localparam int DEPTH   = 2 ** ADDR_W;
   localparam int BYTE_W  = 8;

   localparam logic [3:0] OP_HALT = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GET_LEN = 3'd1,
      ST_GET_HI  = 3'd2,
      ST_GET_LO  = 3'd3,
      ST_WRITE   = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_GET_CHK = 3'd5,
`endif
      ST_DONE    = 3'd6
   } load_state_t;

   // States in which the loader consumes a stream byte.
   function automatic logic accepts_bytes(input load_state_t s);
      case (s)
         ST_GET_LEN, ST_GET_HI, ST_GET_LO: accepts_bytes = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_GET_CHK:                       accepts_bytes = 1'b1;
`endif
         default:                          accepts_bytes = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake (source -> loader) and instruction-memory write bus
// (loader -> memory) used by imem_loader.
interface byte_stream_if;
   logic [7:0] byte_in;
   logic       byte_valid;
   logic       byte_ready;

   modport master (output byte_in, output byte_valid, input  byte_ready);
   modport slave  (input  byte_in, input  byte_valid, output byte_ready);
endinterface

interface imem_wr_if #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 16
);
   logic               wr_en;
   logic [ADDR_W-1:0]  wr_addr;
   logic [INSTR_W-1:0] wr_data;

   modport master (output wr_en, output wr_addr, output wr_data);
   modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/imem_loader.sv
// Program loader: length byte N, then 2N data bytes (high first) written as
// words from address 0. IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
import risc_pkg::*;

module imem_loader #(
   parameter int ADDR_W  = risc_pkg::ADDR_W,
   parameter int INSTR_W = risc_pkg::INSTR_W,
   parameter int DEPTH   = 2 ** ADDR_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   byte_stream_if.slave bs,
   imem_wr_if.master    wr,
   output logic         cpu_hold,
   output logic         done,
   output logic         err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam load_state_t ST_END = ST_GET_CHK;
`else
   localparam load_state_t ST_END = ST_DONE;
`endif

   load_state_t        state, state_nxt;
   logic [ADDR_W:0]    remaining;
   logic [ADDR_W-1:0]  addr;
   logic [INSTR_W-1:0] data;
   logic               byte_ready_q;
   logic               wr_en_q;
   logic               hold_q;
   logic               done_q;
   logic               take;
   logic               last_word;
   logic [ADDR_W:0]    len_count;

   assign take      = bs.byte_valid && byte_ready_q;
   assign last_word = (remaining == (ADDR_W+1)'(1));
   assign len_count = (bs.byte_in == 8'd0) ? (ADDR_W+1)'(DEPTH)
                                           : (ADDR_W+1)'(bs.byte_in);

   // NOTE: state_nxt gets its default before the case so every path assigns it and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_DONE: if (start) state_nxt = ST_GET_LEN;
         ST_GET_LEN:       if (take)  state_nxt = ST_GET_HI;
         ST_GET_HI:        if (take)  state_nxt = ST_GET_LO;
         ST_GET_LO:        if (take)  state_nxt = ST_WRITE;
         ST_WRITE:         state_nxt = last_word ? ST_END : ST_GET_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_GET_CHK:       if (take)  state_nxt = ST_DONE;
`endif
         default:          state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         remaining    <= '0;
         addr         <= '0;
         data         <= '0;
         byte_ready_q <= 1'b0;
         wr_en_q      <= 1'b0;
         hold_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state        <= state_nxt;
         byte_ready_q <= accepts_bytes(state_nxt);
         wr_en_q      <= (state_nxt == ST_WRITE);
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  addr   <= '0;
                  hold_q <= 1'b1;
                  done_q <= 1'b0;
               end
            end
            ST_GET_LEN: if (take) remaining <= len_count;
            ST_GET_HI:  if (take) data[INSTR_W-1:INSTR_W-8] <= bs.byte_in;
            ST_GET_LO:  if (take) data[7:0] <= bs.byte_in;
            ST_WRITE: begin
               // Address wraps mod DEPTH after the last word of a full-depth image.
               addr      <= addr + 1'b1;
               remaining <= remaining - 1'b1;
`ifndef IMEM_LOADER_CHECKSUM_EN
               if (last_word) begin
                  hold_q <= 1'b0;
                  done_q <= 1'b1;
               end
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_GET_CHK: begin
               if (take) begin
                  hold_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] acc;
   logic       err_q;

   // Running XOR over data bytes only; the length byte is excluded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc   <= '0;
         err_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: if (start) begin
               acc   <= '0;
               err_q <= 1'b0;
            end
            ST_GET_HI, ST_GET_LO: if (take) acc <= acc ^ bs.byte_in;
            ST_GET_CHK:           if (take) err_q <= (bs.byte_in != acc);
            default: ;
         endcase
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign bs.byte_ready = byte_ready_q;
   assign wr.wr_en      = wr_en_q;
   assign wr.wr_addr    = addr;
   assign wr.wr_data    = data;
   assign cpu_hold      = hold_q;
   assign done          = done_q;

endmodule
